// File: rtl/multiword_add_seq_pkg.sv
// ============================================================================
// Module : multiword_add_seq_pkg
// Brief  : FSM encodings shared by the multi-word add sequencer.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package multiword_add_seq_pkg;

  localparam int STATE_W = 2;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

endpackage

`default_nettype wire

// File: rtl/multiword_add_seq_limb_add_slice.sv
// ============================================================================
// Module : limb_add_slice
// Brief  : Combinational LIMB_W-bit carry adder, {co,s} = x + y + ci.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module limb_add_slice #(
  parameter int LIMB_W = 8
) (
  input  logic [LIMB_W-1:0] x,
  input  logic [LIMB_W-1:0] y,
  input  logic              ci,
  output logic [LIMB_W-1:0] s,
  output logic              co
);

  assign {co, s} = {1'b0, x} + {1'b0, y} + {{LIMB_W{1'b0}}, ci};

endmodule

`default_nettype wire

// File: rtl/multiword_add_seq.sv
// ============================================================================
// Module : multiword_add_seq
// Brief  : Wide add performed limb by limb, LSB first, over one shared slice.
//          Define MULTIWORD_ADD_SEQ_OVERFLOW_EN to enable the signed overflow flag.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module multiword_add_seq
  import multiword_add_seq_pkg::*;
#(
  parameter int LIMB_W = 8,
  parameter int NLIMBS = 4,
  parameter int IDX_W  = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start_valid,
  output logic                     start_ready,
  input  logic [LIMB_W*NLIMBS-1:0] a,
  input  logic [LIMB_W*NLIMBS-1:0] b,
  input  logic                     cin,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic [LIMB_W*NLIMBS-1:0] sum,
  output logic                     cout,
  output logic                     overflow,
  output logic                     busy,
  output logic [IDX_W-1:0]         limb_idx
);

  localparam int TW = LIMB_W * NLIMBS;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NLIMBS - 1);

  logic [STATE_W-1:0] state;
  logic [TW-1:0]      a_r;
  logic [TW-1:0]      b_r;
  logic [TW-1:0]      sum_r;
  logic               carry;
  logic               cout_r;
  logic [IDX_W-1:0]   idx;
  logic [LIMB_W-1:0]  x;
  logic [LIMB_W-1:0]  y;
  logic [LIMB_W-1:0]  s;
  logic               co;
  logic               last;

  assign x    = a_r[int'(idx)*LIMB_W +: LIMB_W];
  assign y    = b_r[int'(idx)*LIMB_W +: LIMB_W];
  assign last = (idx == LAST_IDX);

  limb_add_slice #(.LIMB_W(LIMB_W)) u_slice (
    .x  (x),
    .y  (y),
    .ci (carry),
    .s  (s),
    .co (co)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      a_r    <= '0;
      b_r    <= '0;
      sum_r  <= '0;
      carry  <= 1'b0;
      cout_r <= 1'b0;
      idx    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start_valid) begin
            a_r   <= a;
            b_r   <= b;
            carry <= cin;
            idx   <= '0;
            state <= ST_RUN;
          end
        end
        ST_RUN: begin
          sum_r[int'(idx)*LIMB_W +: LIMB_W] <= s;
          carry <= co;
          if (last) begin
            cout_r <= co;
            state  <= ST_DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        ST_DONE: begin
          if (res_ready) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef MULTIWORD_ADD_SEQ_OVERFLOW_EN
  logic ovf_r;

  // Top bit of the final slice result is the sign of the full-width sum.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_r <= 1'b0;
    end else if (state == ST_RUN && last) begin
      ovf_r <= (a_r[TW-1] == b_r[TW-1]) && (s[LIMB_W-1] != a_r[TW-1]);
    end
  end

  assign overflow = ovf_r;
`else
  assign overflow = 1'b0;
`endif

  assign start_ready = (state == ST_IDLE);
  assign res_valid   = (state == ST_DONE);
  assign busy        = (state == ST_RUN);
  assign sum         = sum_r;
  assign cout        = cout_r;
  assign limb_idx    = idx;

endmodule

`default_nettype wire

// File: tb/tb_multiword_add_seq.sv
// ============================================================================
// Module : tb_multiword_add_seq
// Brief  : Directed self-checking bench for multiword_add_seq (8x4 limbs).
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_multiword_add_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start_valid = 1'b0;
  logic        start_ready;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        cin = 1'b0;
  logic        res_valid;
  logic        res_ready = 1'b0;
  logic [31:0] sum;
  logic        cout;
  logic        overflow;
  logic        busy;
  logic [1:0]  limb_idx;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  multiword_add_seq #(.LIMB_W(8), .NLIMBS(4), .IDX_W(2)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_valid (start_valid),
    .start_ready (start_ready),
    .a           (a),
    .b           (b),
    .cin         (cin),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .sum         (sum),
    .cout        (cout),
    .overflow    (overflow),
    .busy        (busy),
    .limb_idx    (limb_idx)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, want 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Accepts one operation and checks the per-cycle RUN trace and the result.
  task automatic do_add(input logic [31:0] av, input logic [31:0] bv, input logic ci,
                        input logic [31:0] es, input logic ec, input logic eo,
                        input bit release_res);
    int t;
    t = 0;
    while (!start_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk("start_ready_before_accept", 32'(start_ready), 32'd1);
    a = av; b = bv; cin = ci; start_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("limb_idx_run", 32'(limb_idx), 32'(i));
      chk("busy_run", 32'(busy), 32'd1);
      chk("res_valid_early", 32'(res_valid), 32'd0);
      chk("start_ready_run", 32'(start_ready), 32'd0);
      if (i < 3) @(negedge clk);
    end
    @(negedge clk);
    chk("res_valid_done", 32'(res_valid), 32'd1);
    chk("sum", sum, es);
    chk("cout", 32'(cout), 32'(ec));
    chk("overflow", 32'(overflow), 32'(eo));
    chk("limb_idx_done", 32'(limb_idx), 32'd3);
    if (release_res) begin
      res_ready = 1'b1;
      @(negedge clk);
      res_ready = 1'b0;
      chk("res_valid_after_take", 32'(res_valid), 32'd0);
    end
  endtask

  logic exp_ovf_pos;
  bit   saw_valid;

  initial begin
`ifdef MULTIWORD_ADD_SEQ_OVERFLOW_EN
    exp_ovf_pos = 1'b1;
`else
    exp_ovf_pos = 1'b0;
`endif
    // Reset values
    repeat (2) @(negedge clk);
    chk("rst_start_ready", 32'(start_ready), 32'd1);
    chk("rst_res_valid", 32'(res_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_sum", sum, 32'd0);
    chk("rst_cout", 32'(cout), 32'd0);
    chk("rst_limb_idx", 32'(limb_idx), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    do_add(32'd100, 32'd50, 1'b0, 32'd150, 1'b0, 1'b0, 1'b1);
    do_add(32'hFFFF_FFFF, 32'h0, 1'b1, 32'h0, 1'b1, 1'b0, 1'b1);
    do_add(32'h00FF_00FF, 32'h0001_0001, 1'b0, 32'h0100_0100, 1'b0, 1'b0, 1'b1);
    do_add(32'h7FFF_FFFF, 32'h1, 1'b0, 32'h8000_0000, 1'b0, exp_ovf_pos, 1'b1);

    // Backpressure: hold result while a second request is offered
    do_add(32'hFFFF_FFFF, 32'h1, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    a = 32'h1234_5678; b = 32'h1111_1111; cin = 1'b1;
    for (int i = 0; i < 5; i++) begin
      start_valid = (i % 2 == 0);
      @(negedge clk);
      chk("bp_res_valid", 32'(res_valid), 32'd1);
      chk("bp_start_ready", 32'(start_ready), 32'd0);
      chk("bp_sum", sum, 32'h0);
      chk("bp_cout", 32'(cout), 32'd1);
    end
    start_valid = 1'b0;
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    chk("bp_release_res_valid", 32'(res_valid), 32'd0);
    chk("bp_release_start_ready", 32'(start_ready), 32'd1);
    repeat (3) @(negedge clk);
    chk("bp_no_queued_busy", 32'(busy), 32'd0);
    chk("bp_no_queued_sum", sum, 32'h0);
    do_add(32'h0000_0001, 32'h0000_0002, 1'b1, 32'h0000_0004, 1'b0, 1'b0, 1'b1);

    // Reset during RUN at limb 2
    a = 32'h0F0F_0F0F; b = 32'h0101_0101; cin = 1'b0; start_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start_valid = 1'b0;
    begin
      int t;
      t = 0;
      while (limb_idx != 2'd2 && t < 20) begin
        @(negedge clk);
        t++;
      end
      chk("mid_run_reached_idx2", 32'(limb_idx), 32'd2);
    end
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_sum", sum, 32'h0);
    chk("mid_rst_limb_idx", 32'(limb_idx), 32'd0);
    saw_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (i == 1) rst_n = 1'b1;
      if (res_valid) saw_valid = 1'b1;
    end
    chk("mid_rst_no_res_valid", 32'(saw_valid), 32'd0);
    chk("mid_rst_start_ready", 32'(start_ready), 32'd1);

    do_add(32'd200, 32'd100, 1'b1, 32'd301, 1'b0, 1'b0, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire

// File: doc/multiword_add_seq.md
Name: multiword_add_seq

Overview:
- Sequencer that performs a wide (LIMB_W*NLIMBS-bit) addition by reusing a single LIMB_W-bit carry adder over NLIMBS cycles, least-significant limb first.
- The limb carry is held in a register between cycles.
- Sits between a requester (start handshake) and a consumer (result handshake). It is the controller for the carry-adder datapath.

Parameters:
- LIMB_W, 8, width of one adder slice in bits (>=1).
- NLIMBS, 4, number of limbs per operation (>=1). Total operand width TW = LIMB_W*NLIMBS.
- IDX_W, 2, width of limb index counter; must satisfy 2**IDX_W >= NLIMBS.

Ports:
- clk  input  1  single clock, all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start_valid  input  1  requester has operands.
- start_ready  output  1  block can accept operands.
- a  input  TW  operand A, sampled on accept.
- b  input  TW  operand B, sampled on accept.
- cin  input  1  carry into limb 0, sampled on accept.
- res_valid  output  1  result available.
- res_ready  input  1  consumer takes result.
- sum  output  TW  result, stable while res_valid=1.
- cout  output  1  carry out of the top limb.
- overflow  output  1  signed overflow flag (see Optional Feature).
- busy  output  1  high in RUN.
- limb_idx  output  IDX_W  current limb being added (debug/visibility).

Behaviour:
- Reset (async, rst_n=0):
  - State goes to IDLE.
  - start_ready=1 once in IDLE; res_valid=0, busy=0.
  - sum=0, cout=0, overflow=0, limb_idx=0, carry reg=0, operand regs=0.
- FSM states:
  - IDLE: start_ready=1. On start_valid&&start_ready, capture a, b, cin; set limb_idx=0, carry=cin; go to RUN.
  - RUN: start_ready=0, busy=1.
    - Each cycle: limb result {c, s} = a_r[idx] + b_r[idx] + carry, all operands zero-extended to LIMB_W+1 bits.
    - Write s into sum[idx*LIMB_W +: LIMB_W] and set carry=c.
    - If idx==NLIMBS-1: cout=c, go to DONE. Otherwise idx=idx+1.
  - DONE: res_valid=1; sum, cout and overflow are held. On res_ready=1, go to IDLE and drop res_valid on that edge.
- Latency:
  - Accept edge E; res_valid=1 after edge E+NLIMBS.
  - Next accept is possible no earlier than edge E+NLIMBS+2, i.e. res_ready=1 in the first DONE cycle, then one IDLE cycle.
- Start while not IDLE is ignored: start_ready=0, operands are not sampled, and there is no queuing.
- NLIMBS=1: RUN lasts one cycle.
- All-ones plus carry wraps: sum=0, cout=1.
- Backpressure: res_ready=0 holds DONE indefinitely, with outputs frozen.
- Reset mid-RUN or mid-DONE: the operation is aborted, all outputs return to reset values, and no res_valid pulse occurs.
- sum is written limb by limb during RUN. Consumers may only rely on it when res_valid=1.
- limb_idx stays at NLIMBS-1 in DONE and clears to 0 on the next accept.

Optional Feature:
- Macro: MULTIWORD_ADD_SEQ_OVERFLOW_EN.
- Defined:
  - On the final RUN cycle, overflow = (a_r[TW-1]==b_r[TW-1]) && (s[LIMB_W-1]!=a_r[TW-1]).
  - This is two's-complement signed overflow of the full-width add, including cin.
  - The flag is registered with cout.
- Not defined:
  - overflow is tied to 1'b0.
  - The sign-bit comparison logic is absent; no extra registers are added.

Decomposition:
- Shared constants header (`include, Verilog-2001): FSM state encodings ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2; 2-bit state width.
- One natural sub-module: limb_add_slice (LIMB_W param).
  - Ports: x, y, ci, s, co.
  - Purely combinational {co,s}=x+y+ci.
  - Instantiated once and driven by indexed part-selects of the operand registers.

Test Plan (LIMB_W=8, NLIMBS=4):
- Simple add: a=100, b=50, cin=0 -> sum=150, cout=0, res_valid exactly 4 edges after accept, limb_idx sequence 0,1,2,3.
- Full wrap: a=32'hFFFFFFFF, b=0, cin=1 -> sum=0, cout=1; the carry must ripple through all 4 limbs.
- Cross-limb carry: a=32'h00FF00FF, b=32'h00010001 -> sum=32'h01000100, cout=0.
- Backpressure and ignored start:
  - Hold res_ready=0 for 5 cycles while pulsing start_valid -> sum/cout stable, start_ready=0, second request not taken.
  - Release res_ready -> IDLE; the next accept works.
- Overflow, macro defined: a=32'h7FFFFFFF, b=1 -> overflow=1, sum=32'h80000000.
- Overflow, either build: a=32'hFFFFFFFF, b=1 -> overflow=0. With the macro undefined, overflow=0 for all vectors.
- Reset mid-RUN: assert rst_n=0 at limb_idx=2 -> busy=0, res_valid never pulses, sum=0, start_ready=1 after release.
- Post-reset: a fresh add of 200+100+cin=1 yields sum=301.
